// File: rtl/sw_input_port_if.sv
// sw_input_port_if: CPU read port of the switch/button input block.
interface sw_input_port_if;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  modport master(output rd_en, rd_addr, input rd_data, rd_valid);
  modport slave(input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/sw_input_port.sv
// sw_input_port: synchronizes and debounces slide switches and push buttons, exposes them over a 4-word read port.
// Define SW_INPUT_PORT_IRQ_EN to drive irq from the sticky flags; otherwise irq is tied low.
module sw_input_port #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        sw,
  input  logic [3:0]        key,
  sw_input_port_if.slave    bus,
  output logic              irq
);
  localparam int cw = $clog2(DEBOUNCE_CYCLES);
  localparam logic [cw-1:0] last = cw'(DEBOUNCE_CYCLES - 1);
  logic [7:0]    sw_m, sw_s, sw_db;
  logic [3:0]    key_m, key_s, key_db;
  logic [cw-1:0] sw_cnt, key_cnt;
  logic          sw_changed, key_event;
  logic          sw_diff, sw_acc, key_diff, key_acc, key_press, clr;
  logic [31:0]   rd_mux;
  always_comb begin
    sw_diff   = sw_s != sw_db;
    sw_acc    = sw_diff && sw_cnt == last;
    key_diff  = key_s != key_db;
    key_acc   = key_diff && key_cnt == last;
    key_press = key_acc && |(key_db & ~key_s);
    clr       = bus.rd_en && bus.rd_addr == 2'd3;
    rd_mux    = bus.rd_addr == 2'd0 ? {28'b0, sw_db[3:0]} :
                bus.rd_addr == 2'd1 ? {28'b0, sw_db[7:4]} :
                bus.rd_addr == 2'd2 ? {28'b0, ~key_db} :
                                      {30'b0, key_event, sw_changed};
  end
  // Counters clear whenever the synced value matches the debounced one, so a bounce back restarts the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_m         <= 8'h00;
      sw_s         <= 8'h00;
      sw_db        <= 8'h00;
      key_m        <= 4'hF;
      key_s        <= 4'hF;
      key_db       <= 4'hF;
      sw_cnt       <= '0;
      key_cnt      <= '0;
      sw_changed   <= 1'b0;
      key_event    <= 1'b0;
      bus.rd_data  <= 32'h0;
      bus.rd_valid <= 1'b0;
    end else begin
      sw_m         <= sw;
      sw_s         <= sw_m;
      key_m        <= key;
      key_s        <= key_m;
      sw_cnt       <= (!sw_diff || sw_acc) ? '0 : sw_cnt + cw'(1);
      key_cnt      <= (!key_diff || key_acc) ? '0 : key_cnt + cw'(1);
      sw_db        <= sw_acc ? sw_s : sw_db;
      key_db       <= key_acc ? key_s : key_db;
      sw_changed   <= sw_acc | (sw_changed & ~clr);
      key_event    <= key_press | (key_event & ~clr);
      bus.rd_valid <= bus.rd_en;
      bus.rd_data  <= bus.rd_en ? rd_mux : bus.rd_data;
    end
  end
`ifdef SW_INPUT_PORT_IRQ_EN
  always_ff @(posedge clock) begin
    if (!reset) irq <= 1'b0;
    else irq <= sw_changed | key_event;
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_sw_input_port.sv
// tb_sw_input_port: directed vector table plus hand-written debounce, same-edge, burst and reset sequences (DEBOUNCE_CYCLES=4).
module tb_sw_input_port;
`ifdef SW_INPUT_PORT_IRQ_EN
  localparam bit irq_on = 1'b1;
`else
  localparam bit irq_on = 1'b0;
`endif
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [3:0] key;
  logic       irq;
  int         n_vec = 0;
  int         n_bad = 0;
  sw_input_port_if bus();
  sw_input_port #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .sw(sw), .key(key), .bus(bus), .irq(irq)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [7:0]  sw;
    logic [3:0]  key;
    int          pre;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        irq;
  } vec_t;
  vec_t tbl[17];
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic do_read(input string name, input logic [1:0] addr, input logic [31:0] data, input logic exp_irq);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    step();
    bus.rd_en = 1'b0;
    chk({name, " valid"}, {31'b0, bus.rd_valid}, 32'h1);
    chk({name, " data"}, bus.rd_data, data);
    chk({name, " irq"}, {31'b0, irq}, {31'b0, exp_irq & irq_on});
  endtask
  initial begin
    tbl[0]  = '{8'hA5, 4'hF, 5, 2'd0, 32'h0, 1'b0};
    tbl[1]  = '{8'hA5, 4'hF, 0, 2'd0, 32'h5, 1'b1};
    tbl[2]  = '{8'hA5, 4'hF, 0, 2'd1, 32'hA, 1'b1};
    tbl[3]  = '{8'hA5, 4'hF, 0, 2'd3, 32'h1, 1'b1};
    tbl[4]  = '{8'hA5, 4'hF, 0, 2'd3, 32'h0, 1'b0};
    tbl[5]  = '{8'hA5, 4'hB, 5, 2'd2, 32'h0, 1'b0};
    tbl[6]  = '{8'hA5, 4'hB, 0, 2'd2, 32'h4, 1'b1};
    tbl[7]  = '{8'hA5, 4'hF, 6, 2'd2, 32'h0, 1'b1};
    tbl[8]  = '{8'hA5, 4'hF, 0, 2'd3, 32'h2, 1'b1};
    tbl[9]  = '{8'hA5, 4'hF, 0, 2'd3, 32'h0, 1'b0};
    tbl[10] = '{8'h3C, 4'hF, 6, 2'd1, 32'h3, 1'b1};
    tbl[11] = '{8'h3C, 4'hF, 0, 2'd0, 32'hC, 1'b1};
    tbl[12] = '{8'h3C, 4'hF, 0, 2'd3, 32'h1, 1'b1};
    tbl[13] = '{8'h3C, 4'hF, 0, 2'd3, 32'h0, 1'b0};
    tbl[14] = '{8'h3C, 4'h0, 6, 2'd2, 32'hF, 1'b1};
    tbl[15] = '{8'h3C, 4'h0, 0, 2'd3, 32'h2, 1'b1};
    tbl[16] = '{8'h3C, 4'hF, 6, 2'd3, 32'h0, 1'b0};
    reset       = 1'b0;
    sw          = 8'h00;
    key         = 4'hF;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 2'd0;
    step();
    step();
    chk("reset valid", {31'b0, bus.rd_valid}, 32'h0);
    chk("reset data", bus.rd_data, 32'h0);
    chk("reset irq", {31'b0, irq}, 32'h0);
    reset     = 1'b1;
    bus.rd_en = 1'b0;
    step();
    chk("no valid after reset read", {31'b0, bus.rd_valid}, 32'h0);
    step();
    for (int i = 0; i < 17; i++) begin
      sw  = tbl[i].sw;
      key = tbl[i].key;
      for (int j = 0; j < tbl[i].pre; j++) step();
      do_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data, tbl[i].irq);
    end
    // sw[0] bounces with a 2-cycle period, then settles high
    for (int i = 0; i < 10; i++) begin
      sw[0] = ~sw[0];
      step();
      step();
    end
    sw[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    do_read("bounce edge6", 2'd0, 32'hC, 1'b0);
    do_read("bounce edge7", 2'd0, 32'hD, 1'b1);
    do_read("bounce flags", 2'd3, 32'h1, 1'b1);
    // second change to another non-debounced value keeps the count running
    sw = 8'h3F;
    step();
    step();
    sw = 8'h7F;
    for (int i = 0; i < 3; i++) step();
    do_read("retarget edge6", 2'd1, 32'h3, 1'b0);
    do_read("retarget edge7", 2'd1, 32'h7, 1'b1);
    do_read("retarget flags", 2'd3, 32'h1, 1'b1);
    // flag read on the very edge the press is accepted
    key = 4'hE;
    for (int i = 0; i < 5; i++) step();
    do_read("same edge read", 2'd3, 32'h0, 1'b0);
    do_read("same edge after", 2'd3, 32'h2, 1'b1);
    key = 4'hF;
    for (int i = 0; i < 6; i++) step();
    do_read("release no event", 2'd3, 32'h0, 1'b0);
    do_read("release key view", 2'd2, 32'h0, 1'b0);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      step();
      chk($sformatf("burst%0d valid", i), {31'b0, bus.rd_valid}, 32'h1);
      chk($sformatf("burst%0d data", i), bus.rd_data, i == 0 ? 32'hF : i == 1 ? 32'h7 : 32'h0);
    end
    bus.rd_en = 1'b0;
    do_read("pre-hold read", 2'd0, 32'hF, 1'b0);
    step();
    step();
    chk("hold valid", {31'b0, bus.rd_valid}, 32'h0);
    chk("hold data", bus.rd_data, 32'hF);
    // reset with switches already up yields a power-up change notification
    reset     = 1'b0;
    bus.rd_en = 1'b1;
    step();
    step();
    chk("mid reset valid", {31'b0, bus.rd_valid}, 32'h0);
    chk("mid reset data", bus.rd_data, 32'h0);
    chk("mid reset irq", {31'b0, irq}, 32'h0);
    reset     = 1'b1;
    bus.rd_en = 1'b0;
    step();
    chk("mid reset no valid", {31'b0, bus.rd_valid}, 32'h0);
    for (int i = 0; i < 4; i++) step();
    do_read("powerup edge6", 2'd1, 32'h0, 1'b0);
    do_read("powerup edge7", 2'd1, 32'h7, 1'b1);
    do_read("powerup flags", 2'd3, 32'h1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sw_input_port.md
SW_INPUT_PORT -- requirements
Module: sw_input_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16 (range 2..65535): consecutive stable cycles needed to accept a new input value.
REQ-002 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-004 SHALL have port sw  input  8  raw board slide switches, asynchronous to clock.
REQ-005 SHALL have port key  input  4  raw push buttons, active-low (pressed = 0), asynchronous to clock.
REQ-006 SHALL have port rd_en  input  1  CPU read strobe, one transfer per cycle it is high.
REQ-007 SHALL have port rd_addr  input  2  CPU word select, sampled with rd_en.
REQ-008 SHALL have port rd_data  output  32  registered read data.
REQ-009 SHALL have port rd_valid  output  1  high exactly one cycle after each accepted rd_en.
REQ-010 SHALL have port irq  output  1  level interrupt request to CPU.

Function
REQ-011 SHALL pass sw and key each through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep separate debounce counters for the sw group and the key group; each counter is sized ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 Per group: synced == debounced -> counter cleared; synced != debounced -> counter increments.
REQ-014 Per group: debounced <= synced and counter cleared on the edge where synced != debounced and counter == DEBOUNCE_CYCLES-1; the group's value must therefore differ for DEBOUNCE_CYCLES consecutive edges.
REQ-015 A synced value that changes again before acceptance (e.g. bounce back to the debounced value) SHALL clear the counter; a change to a different non-debounced value SHALL NOT clear it.
REQ-016 Pin-to-debounced latency SHALL be DEBOUNCE_CYCLES+2 cycles for a clean step.
REQ-017 sw_changed (sticky) SHALL set on any edge where the sw debounced value updates.
REQ-018 key_event (sticky) SHALL set on any edge where any debounced key bit goes 1->0 (press); releases do not set it.
REQ-019 Read map, data registered on the rd_en edge: addr 0 -> {28'b0, sw_db[3:0]}; addr 1 -> {28'b0, sw_db[7:4]}; addr 2 -> {28'b0, ~key_db} (1 = pressed); addr 3 -> {30'b0, key_event, sw_changed}.
REQ-020 Read latency SHALL be 1 cycle; back-to-back rd_en every cycle SHALL return one rd_valid per request, in order, no stalls.
REQ-021 A read of addr 3 SHALL return the flags as held before that edge and clear both flags on the same edge.
REQ-022 Set and clear on the same edge SHALL leave the flag set (set wins); the read returns the pre-edge value.
REQ-023 With rd_en low, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-024 Reads of addr 0..2 SHALL NOT alter any flag.

Reset
REQ-025 On reset==0 at a rising edge: sw synchronizers and sw_db <= 8'h00; key synchronizers and key_db <= 4'hF; both counters <= 0; both flags <= 0; rd_data <= 0; rd_valid <= 0; irq <= 0.
REQ-026 Reset SHALL override any rd_en in the same cycle; no rd_valid follows a read issued while reset==0.
REQ-027 After reset release with non-zero switches, sw_db SHALL update after DEBOUNCE_CYCLES+2 cycles and set sw_changed (intended power-up notification).

Configuration
REQ-028 Macro SW_INPUT_PORT_IRQ_EN defined: irq is a register equal to (sw_changed | key_event), updated every edge, so it drops one cycle after the clearing addr-3 read.
REQ-029 Macro SW_INPUT_PORT_IRQ_EN undefined: irq SHALL be constant 0; flags and read map unchanged.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, then sw=8'hA5 held -> sw_db=8'hA5 after 6 cycles; addr 0 reads 32'h5, addr 1 reads 32'hA, addr 3 reads 32'h1, next addr 3 read returns 32'h0.
REQ-031 sw[0] toggles every 2 cycles for 20 cycles, then holds 1 -> sw_db[0] unchanged during toggling, becomes 1 exactly 6 cycles after the final toggle.
REQ-032 key[2] driven 0 for 10 cycles, then 1 -> addr 2 reads 32'h4 while pressed; key_event=1, only one event for press+release.
REQ-033 addr-3 read issued on the same edge a key press is accepted -> rd_data=32'h0 (or prior flags), key_event remains 1; next addr-3 read returns bit1=1.
REQ-034 rd_en high 4 cycles with rd_addr 0,1,2,3 -> rd_valid high 4 cycles, data in order, one-cycle latency.
REQ-035 With SW_INPUT_PORT_IRQ_EN: sw change -> irq=1 one cycle after sw_changed sets; addr-3 read -> irq=0 one cycle after the clear; without macro irq stays 0 throughout.
